// File: rtl/simon_sequencer.sv
// simon_sequencer: Simon memory-game sequencer with an LFSR colour source.
// Define SIMON_TIMEOUT_EN to end the game after player inactivity.
module simon_sequencer #(
  parameter int SHOW_CYCLES    = 25000000,
  parameter int GAP_CYCLES     = 12500000,
  parameter int TIMEOUT_CYCLES = 150000000,
  parameter int MAX_LEN        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] btn,
  output logic [3:0] led,
  output logic       simonTurn,
  output logic       gameOver,
  output logic       win,
  output logic [4:0] score
);

  localparam int M1 =
    (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int TMAX =
    (M1 > TIMEOUT_CYCLES) ? M1 : TIMEOUT_CYCLES;
  localparam int TW = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD,
    S_SHOW_ON,
    S_SHOW_OFF,
    S_PLAYER,
    S_RELEASE,
    S_OVER
  } state_t;

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [15:0]   r_lfsr;
  logic [3:0]    r_btn_q;
  logic [4:0]    r_len;
  logic [4:0]    r_idx;
  logic [1:0]    r_seq [32];

  logic [3:0] w_press;
  logic [3:0] w_exp;
  logic [3:0] w_first;
  logic [4:0] w_idx_n;
  logic       w_last;
  logic       w_fb;

  assign w_press = btn & ~r_btn_q;
  assign w_exp   = 4'b0001 << r_seq[r_idx];
  // Step 0 of round 1 is being written this cycle, so bypass it.
  assign w_first = 4'b0001 <<
    ((r_len == 5'd0) ? r_lfsr[1:0] : r_seq[0]);
  assign w_idx_n = r_idx + 5'd1;
  assign w_last  = (w_idx_n == r_len);
  assign w_fb    = r_lfsr[15] ^ r_lfsr[13] ^
                   r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge clk) begin
    if (r_state == S_ADD)
      r_seq[r_len] <= r_lfsr[1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_lfsr    <= 16'hACE1;
      r_btn_q   <= 4'd0;
      r_len     <= 5'd0;
      r_idx     <= 5'd0;
      led       <= 4'd0;
      simonTurn <= 1'b1;
      gameOver  <= 1'b0;
      win       <= 1'b0;
      score     <= 5'd0;
    end else begin
      r_lfsr  <= {r_lfsr[14:0], w_fb};
      r_btn_q <= btn;
      r_timer <= '0;
      unique case (r_state)
        S_IDLE, S_OVER: begin
          if (start) begin
            r_len     <= 5'd0;
            score     <= 5'd0;
            win       <= 1'b0;
            gameOver  <= 1'b0;
            simonTurn <= 1'b1;
            led       <= 4'd0;
            r_state   <= S_ADD;
          end
        end
        S_ADD: begin
          r_len   <= r_len + 5'd1;
          r_idx   <= 5'd0;
          led     <= w_first;
          r_state <= S_SHOW_ON;
        end
        S_SHOW_ON: begin
          if (r_timer == TW'(SHOW_CYCLES - 1)) begin
            led     <= 4'd0;
            r_state <= S_SHOW_OFF;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_SHOW_OFF: begin
          if (r_timer != TW'(GAP_CYCLES - 1)) begin
            r_timer <= r_timer + 1'b1;
          end else if (w_last) begin
            r_idx     <= 5'd0;
            simonTurn <= 1'b0;
            r_state   <= S_PLAYER;
          end else begin
            r_idx   <= w_idx_n;
            led     <= 4'b0001 << r_seq[w_idx_n];
            r_state <= S_SHOW_ON;
          end
        end
        S_PLAYER: begin
          if (w_press == w_exp) begin
            led     <= w_press;
            r_state <= S_RELEASE;
          end else if (w_press != 4'd0) begin
            gameOver <= 1'b1;
            r_state  <= S_OVER;
          end
`ifdef SIMON_TIMEOUT_EN
          else if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
            gameOver <= 1'b1;
            win      <= 1'b0;
            r_state  <= S_OVER;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
`endif
        end
        S_RELEASE: begin
          if (btn != 4'd0) begin
            // Echo only the accepted colour so led stays one-hot.
            led <= btn & w_exp;
          end else begin
            led <= 4'd0;
            if (!w_last) begin
              r_idx   <= w_idx_n;
              r_state <= S_PLAYER;
            end else begin
              score <= score + 5'd1;
              if (r_len == 5'(MAX_LEN)) begin
                win      <= 1'b1;
                gameOver <= 1'b1;
                r_state  <= S_OVER;
              end else begin
                simonTurn <= 1'b1;
                r_state   <= S_ADD;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
